// File: rtl/sprite_line_scanner.sv
// rtl/sprite_line_scanner.sv - per-scanline sprite evaluator with double-buffered hit list
module sprite_line_scanner #(
  parameter int OAM_OBJECTS  = 64,
  parameter int OAM_ADDR_W   = 6,
  parameter int MAX_PER_LINE = 32,
  parameter int SPRITE_H     = 16,
  parameter int Y_W          = 10
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [Y_W-1:0]                         line,
  input  logic                                   swap,
  output logic [OAM_ADDR_W-1:0]                  oam_addr,
  output logic                                   oam_rd_en,
  input  logic [31:0]                            oam_data,
  output logic                                   busy,
  output logic                                   done,
  input  logic [$clog2(MAX_PER_LINE)-1:0]        rd_index,
  output logic [OAM_ADDR_W+$clog2(SPRITE_H):0]   rd_entry,
  output logic [$clog2(MAX_PER_LINE):0]          front_count,
  output logic                                   front_overflow,
  output logic                                   swap_miss
);

  localparam int IDX_W = $clog2(MAX_PER_LINE);
  localparam int ROW_W = $clog2(SPRITE_H);
  localparam int REC_W = OAM_ADDR_W + ROW_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [OAM_ADDR_W-1:0] LAST_ADDR  = OAM_ADDR_W'(OAM_OBJECTS - 1);
  localparam logic [IDX_W:0]        MAX_CNT    = (IDX_W + 1)'(MAX_PER_LINE);
  localparam logic [Y_W-1:0]        SPRITE_H_Y = Y_W'(SPRITE_H);

  logic [1:0]            state;
  logic [Y_W-1:0]        line_q;
  logic                  eval_valid;
  logic [OAM_ADDR_W-1:0] eval_idx;
  logic                  front_sel;

  // Per-bank bookkeeping; entries at or above a bank's count are treated as invalid
  logic [IDX_W:0]        bank_cnt [2];
  logic                  bank_ovf [2];
  logic [REC_W-1:0]      bank_mem [2][MAX_PER_LINE];

  logic                  back_sel;
  logic                  swap_ok;
  logic                  back_next;
  logic [Y_W-1:0]        ypos;
  logic [Y_W-1:0]        diff;
  logic                  hit;
  logic [ROW_W-1:0]      row;
  logic                  bank_full;
  logic                  unused_oam_bits;

  assign back_sel  = ~front_sel;
  // A swap only takes effect outside a scan; start in the same cycle targets the post-swap back bank
  assign swap_ok   = swap && (state != ST_SCAN);
  assign back_next = ~(front_sel ^ swap_ok);

  assign ypos      = Y_W'(oam_data[27:18]);
  // Modular subtraction gives vertical wrap-around for free
  assign diff      = line_q - ypos;
  assign hit       = oam_data[31] && (diff < SPRITE_H_Y);
  // SPRITE_H-1-d equals the bitwise complement of d in ROW_W bits
  assign row       = oam_data[29] ? ~diff[ROW_W-1:0] : diff[ROW_W-1:0];
  assign bank_full = (bank_cnt[back_sel] == MAX_CNT);

  assign unused_oam_bits = ^{oam_data[30], oam_data[28], oam_data[17:0]};

  assign busy           = (state == ST_SCAN);
  assign done           = (state == ST_DONE);
  assign front_count    = bank_cnt[front_sel];
  assign front_overflow = bank_ovf[front_sel];

  // Front-bank read port: indices past the valid count read as zero
  always_comb begin
    rd_entry = '0;
    if ({1'b0, rd_index} < bank_cnt[front_sel]) begin
      rd_entry = {1'b1, bank_mem[front_sel][rd_index]};
    end
  end

  // Scan sequencer: address issue, one-cycle-delayed evaluation, bank fill and swap handling
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      line_q      <= '0;
      oam_addr    <= '0;
      oam_rd_en   <= 1'b0;
      eval_valid  <= 1'b0;
      eval_idx    <= '0;
      front_sel   <= 1'b0;
      bank_cnt[0] <= '0;
      bank_cnt[1] <= '0;
      bank_ovf[0] <= 1'b0;
      bank_ovf[1] <= 1'b0;
      swap_miss   <= 1'b0;
    end else begin
      if (swap_ok) begin
        front_sel <= ~front_sel;
      end

      if (start) begin
        state               <= ST_SCAN;
        line_q              <= line;
        oam_addr            <= '0;
        oam_rd_en           <= 1'b1;
        eval_valid          <= 1'b0;
        bank_cnt[back_next] <= '0;
        bank_ovf[back_next] <= 1'b0;
        swap_miss           <= 1'b0;
      end else if (state == ST_SCAN) begin
        if (oam_rd_en) begin
          eval_valid <= 1'b1;
          eval_idx   <= oam_addr;
          if (oam_addr == LAST_ADDR) begin
            oam_rd_en <= 1'b0;
          end else begin
            oam_addr <= oam_addr + 1'b1;
          end
        end else begin
          eval_valid <= 1'b0;
        end

        if (eval_valid) begin
          if (hit && bank_full) begin
            // List is full: flag overflow and drop whatever read is still in flight
            bank_ovf[back_sel] <= 1'b1;
            state              <= ST_DONE;
            oam_rd_en          <= 1'b0;
            eval_valid         <= 1'b0;
          end else begin
            if (hit) begin
              bank_mem[back_sel][bank_cnt[back_sel][IDX_W-1:0]] <= {eval_idx, row};
              bank_cnt[back_sel] <= bank_cnt[back_sel] + 1'b1;
            end
            if (eval_idx == LAST_ADDR) begin
              state <= ST_DONE;
            end
          end
        end
      end

      if (swap && (state == ST_SCAN)) begin
        swap_miss <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_scanner.sv
// tb/tb_sprite_line_scanner.sv - randomized model-checked bench for sprite_line_scanner
module tb_sprite_line_scanner;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  line;
  logic        swap;
  logic [5:0]  oam_addr;
  logic        oam_rd_en;
  logic [31:0] oam_data;
  logic        busy;
  logic        done;
  logic [4:0]  rd_index;
  logic [10:0] rd_entry;
  logic [5:0]  front_count;
  logic        front_overflow;
  logic        swap_miss;

  sprite_line_scanner dut (
    .clk(clk), .reset(reset), .start(start), .line(line), .swap(swap),
    .oam_addr(oam_addr), .oam_rd_en(oam_rd_en), .oam_data(oam_data),
    .busy(busy), .done(done), .rd_index(rd_index), .rd_entry(rd_entry),
    .front_count(front_count), .front_overflow(front_overflow), .swap_miss(swap_miss)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  logic [31:0] oam [64];

  // OAM memory: word appears one cycle after the read strobe
  initial oam_data = '0;
  always @(posedge clk) if (oam_rd_en) oam_data <= oam[oam_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int e = 0;
  int st_edge, fin_edge;
  bit m_scan, m_done, m_miss;
  int f_cnt, b_cnt, p_cnt, p_stop;
  bit f_ovf, b_ovf, p_ovf;
  int f_idx [32], f_row [32], b_idx [32], b_row [32], p_idx [32], p_row [32];

  function automatic int row_of(input logic [9:0] ln, input logic [31:0] w);
    int d;
    d = (int'(ln) - int'(w[27:18]) + 1024) % 1024;
    if (w[31] && d < 16) return w[29] ? 15 - d : d;
    return -1;
  endfunction

  function automatic void eval_line(input logic [9:0] ln);
    int r;
    p_cnt = 0; p_ovf = 0; p_stop = 0;
    for (int i = 0; i < 64; i++) begin
      r = row_of(ln, oam[i]);
      if (r >= 0) begin
        if (p_cnt == 32) begin p_ovf = 1; p_stop = i; break; end
        p_idx[p_cnt] = i; p_row[p_cnt] = r; p_cnt++;
      end
    end
  endfunction

  function automatic void swap_banks();
    int t;
    bit tb;
    for (int i = 0; i < 32; i++) begin
      t = f_idx[i]; f_idx[i] = b_idx[i]; b_idx[i] = t;
      t = f_row[i]; f_row[i] = b_row[i]; b_row[i] = t;
    end
    t = f_cnt; f_cnt = b_cnt; b_cnt = t;
    tb = f_ovf; f_ovf = b_ovf; b_ovf = tb;
  endfunction

  function automatic logic [10:0] exp_entry(input int ri);
    if (ri < f_cnt) return {1'b1, 6'(f_idx[ri]), 4'(f_row[ri])};
    return '0;
  endfunction

  always @(posedge clk) begin : mdl
    bit was_scan;
    e++;
    if (!reset) begin
      m_scan = 0; m_done = 0; m_miss = 0;
      f_cnt = 0; b_cnt = 0; f_ovf = 0; b_ovf = 0;
    end else begin
      was_scan = m_scan;
      if (swap && !was_scan) swap_banks();
      if (start) begin
        m_miss = 0; b_cnt = 0; b_ovf = 0;
        m_scan = 1; m_done = 0; st_edge = e;
        eval_line(line);
        fin_edge = p_ovf ? e + p_stop + 2 : e + 65;
      end else if (m_scan && e == fin_edge) begin
        m_scan = 0; m_done = 1;
        for (int i = 0; i < 32; i++) begin b_idx[i] = p_idx[i]; b_row[i] = p_row[i]; end
        b_cnt = p_cnt; b_ovf = p_ovf;
      end
      if (swap && was_scan) m_miss = 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_scan));
      chk("done", 32'(done), 32'(m_done));
      chk("swap_miss", 32'(swap_miss), 32'(m_miss));
      chk("front_count", 32'(front_count), 32'(f_cnt));
      chk("front_overflow", 32'(front_overflow), 32'(f_ovf));
      chk("rd_entry", 32'(rd_entry), 32'(exp_entry(int'(rd_index))));
      if (m_scan && (e - st_edge) <= 63) begin
        chk("oam_rd_en", 32'(oam_rd_en), 32'd1);
        chk("oam_addr", 32'(oam_addr), 32'(e - st_edge));
      end else if (!m_scan) begin
        chk("oam_rd_en_idle", 32'(oam_rd_en), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    start = 0;
    swap = 0;
    rd_index = 5'($urandom_range(0, 31));
  endtask

  task automatic do_start(input logic [9:0] l, input bit sw);
    start = 1; line = l; swap = sw;
    step();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin step(); n++; end
    if (n >= 200) chk("done_bound", 32'(n), 32'd0);
  endtask

  task automatic peek(input int idx, input string nm, input logic [10:0] exp);
    rd_index = 5'(idx);
    #1;
    chk(nm, 32'(rd_entry), 32'(exp));
  endtask

  function automatic logic [31:0] mk(input bit en, input bit fl, input logic [9:0] y);
    logic [31:0] w;
    w = $urandom;
    w[31] = en; w[29] = fl; w[27:18] = y;
    return w;
  endfunction

  initial begin
    int n;
    logic [9:0] ln;
    reset = 0; start = 0; swap = 0; line = '0; rd_index = '0;
    for (int i = 0; i < 64; i++) oam[i] = '0;
    repeat (3) step();
    chk_en = 1;

    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(oam_rd_en), 0);
    chk("rst_addr", 32'(oam_addr), 0);
    chk("rst_count", 32'(front_count), 0);
    chk("rst_ovf", 32'(front_overflow), 0);
    chk("rst_miss", 32'(swap_miss), 0);
    for (int i = 0; i < 32; i++) peek(i, "rst_entry", 11'd0);

    chk("mdl_wrap", 32'(row_of(10'd2, mk(1, 0, 10'd1020))), 32'd6);
    chk("mdl_nohit16", 32'(row_of(10'd116, mk(1, 0, 10'd100))), 32'hffffffff);
    chk("mdl_flip", 32'(row_of(10'd5, mk(1, 1, 10'd0))), 32'd10);
    chk("mdl_disabled", 32'(row_of(10'd5, mk(0, 0, 10'd0))), 32'hffffffff);

    reset = 1; step();

    // all disabled
    do_start(10'd5, 0);
    wait_done(n);
    chk("lat_full_scan", 32'(n), 32'd65);
    swap = 1; step();
    chk("t1_count", 32'(front_count), 0);
    chk("t1_ovf", 32'(front_overflow), 0);

    // two hits, one flipped
    oam[3] = mk(1, 0, 10'd0);
    oam[7] = mk(1, 1, 10'd0);
    do_start(10'd5, 0); wait_done(n);
    swap = 1; step();
    chk("t2_count", 32'(front_count), 32'd2);
    peek(0, "t2_e0", 11'b1_000011_0101);
    peek(1, "t2_e1", 11'b1_000111_1010);
    peek(2, "t2_e2", 11'd0);

    // overflow
    for (int i = 0; i < 64; i++) oam[i] = (i < 40) ? mk(1, 0, 10'd100) : mk(0, 0, 10'd100);
    do_start(10'd110, 0); wait_done(n);
    chk("lat_overflow", 32'(n), 32'd34);
    swap = 1; step();
    chk("t3_count", 32'(front_count), 32'd32);
    chk("t3_ovf", 32'(front_overflow), 32'd1);
    peek(0, "t3_e0", 11'b1_000000_1010);
    peek(31, "t3_e31", 11'b1_011111_1010);

    // wrap and height boundary
    for (int i = 0; i < 64; i++) oam[i] = '0;
    oam[0] = mk(1, 0, 10'd1020);
    oam[1] = mk(1, 0, 10'd100);
    do_start(10'd2, 0); wait_done(n);
    swap = 1; step();
    chk("t4_count", 32'(front_count), 32'd1);
    peek(0, "t4_e0", 11'b1_000000_0110);
    peek(1, "t4_e1", 11'd0);
    do_start(10'd116, 0); wait_done(n);
    swap = 1; step();
    chk("t4b_count", 32'(front_count), 32'd0);

    // swap during scan
    do_start(10'd2, 0);
    repeat (5) step();
    swap = 1; step();
    chk("t5_miss", 32'(swap_miss), 32'd1);
    chk("t5_count", 32'(front_count), 32'd0);
    wait_done(n);
    do_start(10'd2, 0);
    chk("t5_miss_clr", 32'(swap_miss), 32'd0);
    wait_done(n);

    // restart mid-scan, then start+swap together
    for (int i = 0; i < 64; i++) oam[i] = '0;
    oam[2]  = mk(1, 0, 10'd5);
    oam[9]  = mk(1, 0, 10'd25);
    oam[12] = mk(1, 1, 10'd28);
    do_start(10'd20, 0);
    repeat (10) step();
    do_start(10'd10, 0); wait_done(n);
    do_start(10'd30, 1);
    chk("t6_count", 32'(front_count), 32'd1);
    peek(0, "t6_e0", 11'b1_000010_0101);
    wait_done(n);
    swap = 1; step();
    chk("t6b_count", 32'(front_count), 32'd2);
    peek(0, "t6b_e0", 11'b1_001001_0101);
    peek(1, "t6b_e1", 11'b1_001100_1101);

    // reset mid-scan
    do_start(10'd10, 0);
    repeat (20) step();
    reset = 0; step();
    chk("t7_busy", 32'(busy), 0);
    chk("t7_count", 32'(front_count), 0);
    peek(0, "t7_e0", 11'd0);
    reset = 1; step();

    // randomized scans
    for (int r = 0; r < 24; r++) begin
      ln = 10'($urandom_range(0, 1023));
      for (int i = 0; i < 64; i++)
        oam[i] = mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    10'((int'(ln) + 1024 - int'($urandom_range(0, (r % 4 == 0) ? 15 : 60))) % 1024));
      do_start(ln, 1'($urandom_range(0, 1)));
      n = 0;
      while (m_scan && n < 300) begin
        if ($urandom_range(0, 15) == 0) swap = 1;
        if ((r % 3 == 1) && n == 20) begin
          start = 1; swap = 0; line = 10'($urandom_range(0, 1023));
        end
        step(); n++;
      end
      if (n >= 300) chk("rand_done_bound", 32'(n), 32'd0);
      repeat ($urandom_range(1, 4)) begin
        if ($urandom_range(0, 1) != 0) swap = 1;
        step();
      end
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(100 * 60000);
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
